// File: rtl/unpool_pkg.sv
// -----------------------------------------------------------------------------
// unpool_pkg
// Shared definitions for the 2x2 nearest-neighbour unpooling sequencer:
//   - state_e     : sequencer phase encoding (3-bit, fixed values)
//   - ceil_log2() : counter-width helper, never returns less than 1
//   - pix_width() : pixel bus width derived from FIXED_BITW * UNITS
// -----------------------------------------------------------------------------
package unpool_pkg;

  // Phases of one input row:
  //   UP_L/UP_R  upper output row, left/right copy of each pixel
  //   LO_PRE     single bubble that primes the line-buffer read
  //   LO_L/LO_R  lower output row replayed from the line buffer
  typedef enum logic [2:0] {
    UP_L   = 3'd0,
    UP_R   = 3'd1,
    LO_L   = 3'd2,
    LO_R   = 3'd3,
    LO_PRE = 3'd4
  } state_e;

  // Smallest r with 2**r >= n. The result is clamped to 1 so that a
  // degenerate (or not yet overridden) parameter still yields legal
  // vector widths.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // One pixel carries UNITS channels of FIXED_BITW bits each.
  function automatic int pix_width(input int fixed_bitw, input int units);
    int w;
    w = fixed_bitw * units;
    return (w < 1) ? 1 : w;
  endfunction

endpackage : unpool_pkg

// File: rtl/unpool_line_ram.sv
// -----------------------------------------------------------------------------
// unpool_line_ram
// Single-row line buffer: DEPTH entries of PIX_W bits, one write port and one
// read port, registered read data (1-cycle latency). rd_data only changes on a
// read enable, so it stays stable between reads.
//
// Ports
//   clock    in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module unpool_line_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int PIX_W = 8
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [0:PIX_W-1] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [0:PIX_W-1] rd_data
);

  logic [0:PIX_W-1] mem [DEPTH];

  // NOTE: storage arrays carry no reset; the sequencer rewrites every entry
  // before reading it, and a reset branch would stop this mapping onto RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule : unpool_line_ram

// File: rtl/unpool_sequencer.sv
// -----------------------------------------------------------------------------
// unpool_sequencer
// Stream-mode 2x2 nearest-neighbour unpooling controller. Each input row is
// emitted with every pixel doubled on the upper output row (the left copy is
// passed through combinationally, the right copy comes from a hold register)
// while being written into a line buffer. The buffer is then replayed, again
// doubling every pixel, for the lower output row; the producer is held off
// for the whole replay.
//
// Parameters
//   W_WIDTH, W_HEIGHT  input feature-map size (output is 2x in both axes)
//   FIXED_BITW, UNITS  pixel = UNITS channels of FIXED_BITW bits
//
// Ports
//   clock       in   rising-edge clock
//   n_rst       in   synchronous active-low reset
//   in_valid    in   in_pixels valid
//   in_ready    out  input beat accepted this cycle
//   in_pixels   in   input pixel
//   out_valid   out  out_pixels valid
//   out_ready   in   consumer accepts this cycle
//   out_pixels  out  unpooled pixel
//   out_vcnt    out  output row    {vcnt, lower-row bit}
//   out_hcnt    out  output column {hcnt, right-copy bit}
//   out_last    out  final beat of the output frame
// -----------------------------------------------------------------------------
module unpool_sequencer
  import unpool_pkg::*;
#(
  parameter  int W_WIDTH    = -1,
  parameter  int W_HEIGHT   = -1,
  parameter  int FIXED_BITW = -1,
  parameter  int UNITS      = -1,
  localparam int PIX_W      = pix_width(FIXED_BITW, UNITS),
  localparam int HW         = ceil_log2(W_WIDTH),
  localparam int VW         = ceil_log2(W_HEIGHT)
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:PIX_W-1] in_pixels,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:PIX_W-1] out_pixels,
  output logic [VW:0]      out_vcnt,
  output logic [HW:0]      out_hcnt,
  output logic             out_last
);

  // Guarded sizes keep elaboration legal even with unset parameters.
  localparam int            DEPTH  = (W_WIDTH  > 0) ? W_WIDTH  : 1;
  localparam int            ROWS   = (W_HEIGHT > 0) ? W_HEIGHT : 1;
  localparam logic [HW-1:0] H_LAST = HW'(DEPTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(ROWS - 1);

  state_e           state_q, state_d;
  logic [HW-1:0]    hcnt_q,  hcnt_d;
  logic [VW-1:0]    vcnt_q,  vcnt_d;
  logic [0:PIX_W-1] hold_q,  hold_d;

  logic             wr_en;
  logic             rd_en;
  logic [HW-1:0]    rd_addr;
  logic [0:PIX_W-1] rd_data;

  // ---------------------------------------------------------------------------
  // Line buffer. Writes happen only in UP_L and reads only in LO_PRE/LO_R, so
  // the two ports are never active in the same cycle.
  // ---------------------------------------------------------------------------
  unpool_line_ram #(
    .DEPTH (DEPTH),
    .AW    (HW),
    .PIX_W (PIX_W)
  ) u_line_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (hcnt_q),
    .wr_data (in_pixels),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state_q <= UP_L;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hold_q  <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, handshakes, line-buffer control and output data
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    hold_d     = hold_q;
    out_valid  = 1'b0;
    in_ready   = 1'b0;
    out_pixels = rd_data;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = hcnt_q;

    unique case (state_q)
      // Left copy on the upper row: the producer talks straight to the
      // consumer, and the accepted pixel is captured for the right copy and
      // for the lower-row replay.
      UP_L: begin
        out_valid  = in_valid;
        in_ready   = out_ready;
        out_pixels = in_pixels;
        if (in_valid && out_ready) begin
          hold_d  = in_pixels;
          wr_en   = 1'b1;
          state_d = UP_R;
        end
      end

      UP_R: begin
        out_valid  = 1'b1;
        out_pixels = hold_q;
        if (out_ready) begin
          if (hcnt_q == H_LAST) begin
            hcnt_d  = '0;
            state_d = LO_PRE;
          end else begin
            hcnt_d  = hcnt_q + HW'(1);
            state_d = UP_L;
          end
        end
      end

      // Bubble cycle: the registered read of entry 0 lands for LO_L.
      LO_PRE: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        state_d = LO_L;
      end

      LO_L: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LO_R;
      end

      // The next read is issued on the accept of the right copy, so rd_data
      // only moves once both copies of the current pixel have gone out.
      LO_R: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (hcnt_q != H_LAST) begin
            rd_en   = 1'b1;
            rd_addr = hcnt_q + HW'(1);
            hcnt_d  = hcnt_q + HW'(1);
            state_d = LO_L;
          end else begin
            hcnt_d  = '0;
            vcnt_d  = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
            state_d = UP_L;
          end
        end
      end

      default: state_d = UP_L;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output coordinates: the low bit of each selects the copy within a 2x2
  // block (right column, lower row).
  // ---------------------------------------------------------------------------
  logic is_right;
  logic is_lower;

  always_comb begin
    is_right = (state_q == UP_R) || (state_q == LO_R);
    is_lower = (state_q == LO_PRE) || (state_q == LO_L) || (state_q == LO_R);
    out_hcnt = {hcnt_q, is_right};
    out_vcnt = {vcnt_q, is_lower};
    out_last = (state_q == LO_R) && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  end

endmodule : unpool_sequencer
